// File: rtl/regfile_gen_if.sv
// Purpose : bundles the register-file access signals (reads, write, issue, status).
// Latency : none; this is a plain signal bundle.
// Backpressure: none; the slave reports its clear sweep on busy and drops requests meanwhile.
// Ports   : master drives rs1/rs2/rd/wdata/we/iss_valid/iss_rd and observes
//           rdata1/rdata2/rs1_pend/rs2_pend/busy; slave is the reverse.
interface regfile_gen_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wdata;
  logic            we;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            busy;

  modport master (
    output rs1, rs2, rd, wdata, we, iss_valid, iss_rd,
    input  rdata1, rdata2, rs1_pend, rs2_pend, busy
  );

  modport slave (
    input  rs1, rs2, rd, wdata, we, iss_valid, iss_rd,
    output rdata1, rdata2, rs1_pend, rs2_pend, busy
  );
endinterface

// File: rtl/regfile_gen.sv
// Purpose : NREGS x XLEN register file with a pending-write scoreboard and a
//           one-register-per-cycle clear sweep after reset (r0 hardwired to 0).
// Latency : reads and pending status are combinational; writes land on the next rising edge.
// Backpressure: busy is high for NREGS cycles after reset; we/iss_valid are dropped then.
// Ports   : clk, reset (synchronous, active-high); bus (regfile_gen_if.slave) carries
//           rs1/rs2/rd/wdata/we/iss_valid/iss_rd in, rdata1/rdata2/rs1_pend/rs2_pend/busy out.
// Config  : define REGFILE_GEN_BYPASS_EN to forward same-cycle write data (and clear the
//           pending flag) to a read port whose index matches rd.
module regfile_gen #(
  parameter int          XLEN    = 64,
  parameter int          NREGS   = 32,
  parameter int          SP_IDX  = 31,
  parameter int unsigned SP_INIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  regfile_gen_if.slave  bus
);

  localparam int              AW       = $clog2(NREGS);
  localparam logic [AW-1:0]   LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0]   SP_IDX_W = AW'(SP_IDX);
  localparam logic [XLEN-1:0] SP_VAL   = XLEN'(SP_INIT);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [NREGS-1:0]           pend_q, pend_d;
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

  logic run;
  logic wr_run;
  logic iss_run;

  assign run     = (state_q == RUN);
  // Index 0 is never a real destination, so writes and issues to it vanish here.
  assign wr_run  = run && bus.we && (bus.rd != '0);
  assign iss_run = run && bus.iss_valid && (bus.iss_rd != '0);

  // Sweep control: the counter walks 0..NREGS-1, one register per cycle, then RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Register array next state: sweep write while clearing, normal write in RUN.
  always_comb begin
    regs_d = regs_q;
    if (state_q == CLEAR) begin
      regs_d[cnt_q] = (cnt_q == SP_IDX_W) ? SP_VAL : '0;
    end else if (wr_run) begin
      regs_d[bus.rd] = bus.wdata;
    end
  end

  // Pending vector: the set is applied after the clear so an issue and a
  // write to the same register in one cycle leave it pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_run) begin
      pend_d[bus.rd] = 1'b0;
    end
    if (iss_run) begin
      pend_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // No reset on the array itself: the sweep that follows every reset rewrites it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero while sweeping and for index 0.
  always_comb begin
    bus.rdata1   = '0;
    bus.rdata2   = '0;
    bus.rs1_pend = 1'b0;
    bus.rs2_pend = 1'b0;
    if (run) begin
      if (bus.rs1 != '0) begin
        bus.rdata1   = regs_q[bus.rs1];
        bus.rs1_pend = pend_q[bus.rs1];
`ifdef REGFILE_GEN_BYPASS_EN
        if (wr_run && (bus.rd == bus.rs1)) begin
          bus.rdata1   = bus.wdata;
          bus.rs1_pend = 1'b0;
        end
`endif
      end
      if (bus.rs2 != '0) begin
        bus.rdata2   = regs_q[bus.rs2];
        bus.rs2_pend = pend_q[bus.rs2];
`ifdef REGFILE_GEN_BYPASS_EN
        if (wr_run && (bus.rd == bus.rs2)) begin
          bus.rdata2   = bus.wdata;
          bus.rs2_pend = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_gen.sv
// Purpose : directed checks of regfile_gen (sweep, r0, scoreboard, bypass, mid-sweep reset).
// Latency : stimulus is driven 1 time unit after each rising edge; outputs checked on the falling edge.
// Backpressure: none; expectations are queued by the stimulus and drained by the monitor.
module tb_regfile_gen;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  logic clk;
  logic reset;

  regfile_gen_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  regfile_gen #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .SP_IDX (31),
    .SP_INIT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           nm;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic            p1;
    logic            p2;
    logic            b;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

`ifdef REGFILE_GEN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic cmp(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp({e.nm, ".rdata1"},   bus.rdata1,           e.r1);
      cmp({e.nm, ".rdata2"},   bus.rdata2,           e.r2);
      cmp({e.nm, ".rs1_pend"}, XLEN'(bus.rs1_pend),  XLEN'(e.p1));
      cmp({e.nm, ".rs2_pend"}, XLEN'(bus.rs2_pend),  XLEN'(e.p2));
      cmp({e.nm, ".busy"},     XLEN'(bus.busy),      XLEN'(e.b));
    end
  end

  task automatic expect_out(input string nm, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                            input logic p1, input logic p2, input logic b);
    exp_t e;
    e.nm = nm; e.r1 = r1; e.r2 = r2; e.p1 = p1; e.p2 = p2; e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.wdata = '0;
    bus.we = 1'b0; bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    cyc();                       // reset edge
    reset = 1'b0;

    // Sweep: busy for exactly NREGS cycles; traffic during it is ignored.
    for (int i = 0; i < NREGS; i++) begin
      idle();
      bus.rs1 = 5'd31;
      bus.rs2 = 5'd3;
      if (i == 5) begin
        bus.we = 1'b1; bus.rd = 5'd3; bus.wdata = 64'hAA;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
      end
      expect_out($sformatf("sweep%0d", i), '0, '0, 1'b0, 1'b0, 1'b1);
      cyc();
    end

    idle(); bus.rs1 = 5'd31; bus.rs2 = 5'd5;
    expect_out("post_sweep_sp", 64'd8, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.rs1 = 5'd3; bus.rs2 = 5'd3;
    expect_out("busy_write_dropped", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();

    // r0 is hardwired.
    idle(); bus.we = 1'b1; bus.rd = 5'd0; bus.wdata = 64'hFF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    expect_out("r0_write_cycle", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    expect_out("r0_after_write", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();

    // Scoreboard on r7.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs2 = 5'd7;
    expect_out("iss7_same_cycle", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.rs2 = 5'd7;
    expect_out("iss7_pending", 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    idle(); bus.we = 1'b1; bus.rd = 5'd7; bus.wdata = 64'h1234; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    if (BYP) expect_out("wr7_cycle", 64'h1234, 64'h1234, 1'b0, 1'b0, 1'b0);
    else     expect_out("wr7_cycle", 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    idle(); bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    expect_out("wr7_done", 64'h1234, 64'h1234, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.we = 1'b1; bus.rd = 5'd7; bus.wdata = 64'h5678; bus.rs1 = 5'd7;
    if (BYP) expect_out("iss_wr7_cycle", 64'h5678, 64'd0, 1'b0, 1'b0, 1'b0);
    else     expect_out("iss_wr7_cycle", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    expect_out("iss_wins", 64'h5678, 64'h5678, 1'b1, 1'b1, 1'b0);
    cyc();
    idle(); bus.we = 1'b1; bus.rd = 5'd7; bus.wdata = 64'h9; bus.rs1 = 5'd7;
    if (BYP) expect_out("wr7_clear_cycle", 64'h9, 64'd0, 1'b0, 1'b0, 1'b0);
    else     expect_out("wr7_clear_cycle", 64'h5678, 64'd0, 1'b1, 1'b0, 1'b0);
    cyc();

    // Write/read same cycle on r9.
    idle(); bus.we = 1'b1; bus.rd = 5'd9; bus.wdata = 64'h55; bus.rs1 = 5'd9; bus.rs2 = 5'd8;
    expect_out("wr9_cycle", BYP ? 64'h55 : 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.rs1 = 5'd9;
    expect_out("wr9_next", 64'h55, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.we = 1'b1; bus.rd = 5'd9; bus.wdata = 64'hDEAD_BEEF_0000_0001;
    bus.rs1 = 5'd9; bus.rs2 = 5'd9;
    if (BYP) expect_out("wr9b_cycle", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 1'b0);
    else     expect_out("wr9b_cycle", 64'h55, 64'h55, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.rs1 = 5'd9; bus.rs2 = 5'd9;
    expect_out("wr9b_next", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 1'b0);
    cyc();

    // Leave state behind that the next reset must erase.
    idle(); bus.we = 1'b1; bus.rd = 5'd31; bus.wdata = 64'h100;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd20;
    cyc();
    idle(); bus.rs1 = 5'd31; bus.rs2 = 5'd20;
    expect_out("pre_reset_state", 64'h100, 64'd0, 1'b0, 1'b1, 1'b0);
    cyc();

    // Reset, then reset again when the sweep counter reaches 12.
    reset = 1'b1; idle();
    cyc();
    reset = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      idle();
      if (i == 12) reset = 1'b1;
      expect_out($sformatf("part_sweep%0d", i), '0, '0, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      idle(); bus.rs1 = 5'd31;
      expect_out($sformatf("resweep%0d", i), '0, '0, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    idle(); bus.rs1 = 5'd31; bus.rs2 = 5'd20;
    expect_out("resweep_done_sp", 64'd8, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(); bus.rs1 = 5'd9; bus.rs2 = 5'd7;
    expect_out("resweep_cleared", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc();

    @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_gen.md
REGFILE_GEN -- requirements
Module: regfile_gen

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, 2..256.
REQ-003 SHALL have parameter SP_IDX, default 31, index of the preset register.
REQ-004 SHALL have parameter SP_INIT, default 8, value loaded into SP_IDX on clear.
REQ-005 SHALL derive AW = $clog2(NREGS) for all index ports.
REQ-006 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports rs1, rs2  input  AW  read indices.
REQ-009 SHALL have port rd  input  AW  write index.
REQ-010 SHALL have port wdata  input  XLEN  write data.
REQ-011 SHALL have port we  input  1  write enable.
REQ-012 SHALL have port iss_valid  input  1  issue strobe; marks iss_rd pending.
REQ-013 SHALL have port iss_rd  input  AW  destination of issued instruction.
REQ-014 SHALL have ports rdata1, rdata2  output  XLEN  read data.
REQ-015 SHALL have ports rs1_pend, rs2_pend  output  1  scoreboard status of rs1/rs2.
REQ-016 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-017 SHALL implement FSM with states CLEAR and RUN; CLEAR entered on reset.
REQ-018 SHALL, in CLEAR, write one register per cycle with index counter 0..NREGS-1: 0 everywhere, SP_INIT at SP_IDX.
REQ-019 SHALL move CLEAR->RUN on the cycle after index NREGS-1 is written; busy = 1 exactly NREGS cycles.
REQ-020 SHALL, while busy, ignore we and iss_valid and drive rdata1/rdata2 = 0 and rs1_pend/rs2_pend = 0.
REQ-021 SHALL, in RUN, provide combinational reads: rdataN = reg[rsN], zero latency.
REQ-022 SHALL, in RUN, commit wdata to reg[rd] on the rising edge when we = 1 and rd != 0.
REQ-023 SHALL hardwire register 0: reads return 0; writes and issues to index 0 are dropped.
REQ-024 SHALL keep an NREGS-bit pending vector: set bit iss_rd on iss_valid, clear bit rd on we.
REQ-025 SHALL, when iss_valid and we target the same nonzero index in one cycle, leave the bit set (issue wins).
REQ-026 SHALL drive rsN_pend = pending[rsN] combinationally; rsN_pend for index 0 is always 0.
REQ-027 SHALL let rs1 = rs2 read the same value and status on both ports.

Reset
REQ-028 SHALL, while reset = 1 at a rising edge, set the counter to 0, clear the pending vector, and enter CLEAR.
REQ-029 SHALL restart the sweep from index 0 if reset is asserted mid-CLEAR; no partial-sweep state survives.
REQ-030 SHALL drive busy = 1 from the first edge with reset = 1 until the sweep completes.

Configuration
REQ-031 SHALL honour macro REGFILE_GEN_BYPASS_EN as follows.
REQ-032 With REGFILE_GEN_BYPASS_EN defined: in RUN, if we = 1, rd != 0 and rsN = rd, rdataN = wdata in the same cycle and rsN_pend = 0.
REQ-033 Without REGFILE_GEN_BYPASS_EN: rdataN shows the old value and the new value appears the cycle after the write edge.

Verification
REQ-034 Reset 1 cycle, then idle -> busy high 32 cycles; afterwards rs1=31 reads 8 and rs1=5 reads 0.
REQ-035 During busy, we=1 rd=3 wdata=0xAA -> ignored; after busy, reg 3 reads 0.
REQ-036 In RUN, we=1 rd=0 wdata=0xFF -> reg 0 still reads 0 and rs1_pend=0 for index 0.
REQ-037 iss_valid rd=7 -> rs2=7 pend=1 next cycle; we rd=7 wdata=0x1234 -> pend=0, reads 0x1234; simultaneous iss and we to rd=7 -> pend stays 1.
REQ-038 we=1 rd=9 wdata=0x55, rs1=9 same cycle -> 0x55 with BYPASS_EN, previous value without it; 0x55 in both builds next cycle.
REQ-039 Reset asserted at sweep index 12 -> sweep restarts at 0; busy stays high NREGS cycles after release.
